pc_fetch_unit: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline: owns the program counter, drives the instruction-memory address, and loads the IF/ID pipeline register.
- It is the consumer of the decode-stage jump interface (PCSrc, JmpAddr).
- On a taken jump it redirects the PC and squashes the single wrong-path instruction already fetched.
- Honours hazard-unit stalls and keeps saturating jump and stall performance counters.

---
 rtl/mips_defs_pkg.sv | 31 +++
 rtl/if_id_reg.sv | 25 ++
 rtl/pc_fetch_unit.sv | 104 ++++++++++
 tb/tb_pc_fetch_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mips_defs_pkg.sv
// Shared MIPS pipeline definitions: NOP encoding, jump opcode, fetch FSM states
// and the IF/ID payload layout.
package mips_defs_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned OP_W = 6;

    localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0000;
    localparam logic [OP_W-1:0] OP_J             = 6'h02;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_BOOT   = 2'd0,
        FS_RUN    = 2'd1,
        FS_SQUASH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{inst: NOP_INST, pc_plus4: '0, valid: 1'b0};

    // Instruction fetches are always word aligned; low byte-offset bits are discarded.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: squash inserts a bubble, load captures, otherwise holds.
module if_id_reg
    import mips_defs_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   load_i,
    input  logic   squash_i,
    input  if_id_t data_i,
    output if_id_t data_o
);

    if_id_t data_q;

    always_ff @(posedge clk) begin
        if (reset || squash_i) begin
            data_q <= IF_ID_BUBBLE;
        end else if (load_i) begin
            data_q <= data_i;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// MIPS instruction-fetch stage: program counter, redirect/squash control,
// IF/ID load and saturating jump/stall performance counters.
module pc_fetch_unit
    import mips_defs_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PCSrc,
    input  logic [31:0]      JmpAddr,
    input  logic             Stall,
    input  logic [31:0]      InstData,
    output logic [31:0]      InstAddr,
    output logic [31:0]      IF_ID_Inst,
    output logic [31:0]      IF_ID_PCPlus4,
    output logic             IF_ID_Valid,
    output logic [CNT_W-1:0] JmpCount,
    output logic [CNT_W-1:0] StallCount
);

    fetch_state_e     state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] jmp_cnt_q, jmp_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic             ifid_load;
    logic             ifid_squash;
    logic [XLEN-1:0]  pc_plus4;
    if_id_t           fetch_data;
    if_id_t           if_id;

    // The byte offset of a jump target has no meaning for word fetches.
    logic             unused_jmp_lsbs;
    assign unused_jmp_lsbs = ^JmpAddr[1:0];

    assign pc_plus4   = pc_q + XLEN'(4);
    assign fetch_data = '{inst: InstData, pc_plus4: pc_plus4, valid: 1'b1};

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        jmp_cnt_d   = jmp_cnt_q;
        stall_cnt_d = stall_cnt_q;
        ifid_load   = 1'b0;
        ifid_squash = 1'b0;

        case (state_q)
            FS_BOOT: begin
                state_d = FS_RUN;
            end
            FS_RUN, FS_SQUASH: begin
                if (Stall) begin
                    stall_cnt_d = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
                end else if ((state_q == FS_RUN) && PCSrc && if_id.valid) begin
                    // Redirect: the instruction fetched this cycle is wrong-path.
                    pc_d        = align_word(JmpAddr);
                    ifid_squash = 1'b1;
                    jmp_cnt_d   = (&jmp_cnt_q) ? jmp_cnt_q : jmp_cnt_q + CNT_W'(1);
                    state_d     = FS_SQUASH;
                end else begin
                    pc_d      = pc_plus4;
                    ifid_load = 1'b1;
                    state_d   = FS_RUN;
                end
            end
            default: begin
                state_d = FS_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FS_BOOT;
            pc_q        <= RESET_PC;
            jmp_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            jmp_cnt_q   <= jmp_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .reset    (reset),
        .load_i   (ifid_load),
        .squash_i (ifid_squash),
        .data_i   (fetch_data),
        .data_o   (if_id)
    );

    assign InstAddr      = pc_q;
    assign IF_ID_Inst    = if_id.inst;
    assign IF_ID_PCPlus4 = if_id.pc_plus4;
    assign IF_ID_Valid   = if_id.valid;
    assign JmpCount      = jmp_cnt_q;
    assign StallCount    = stall_cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed scenarios plus random traffic
// against a cycle-level behavioural model of the fetch stage.
module tb_pc_fetch_unit;

    localparam int unsigned CNT_W = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             PCSrc = 1'b0;
    logic             Stall = 1'b0;
    logic [31:0]      JmpAddr = 32'h0;
    logic [31:0]      InstData;
    logic [31:0]      InstAddr;
    logic [31:0]      IF_ID_Inst;
    logic [31:0]      IF_ID_PCPlus4;
    logic             IF_ID_Valid;
    logic [CNT_W-1:0] JmpCount;
    logic [CNT_W-1:0] StallCount;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(RST_PC), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .PCSrc         (PCSrc),
        .JmpAddr       (JmpAddr),
        .Stall         (Stall),
        .InstData      (InstData),
        .InstAddr      (InstAddr),
        .IF_ID_Inst    (IF_ID_Inst),
        .IF_ID_PCPlus4 (IF_ID_PCPlus4),
        .IF_ID_Valid   (IF_ID_Valid),
        .JmpCount      (JmpCount),
        .StallCount    (StallCount)
    );

    // Address-tagged instruction memory, never zero so it is distinguishable from NOP.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'h5A00_0000) | 32'h0000_0003;
    endfunction

    assign InstData = mem_word(InstAddr);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        valid;
        int          jc;
        int          sc;
    } exp_t;

    exp_t q[$];

    logic [31:0] m_pc, m_inst, m_pc4;
    logic        m_valid;
    int          m_jc, m_sc;
    bit          m_boot;

    int n_vec = 0;
    int n_err = 0;

    // One clock of stimulus; the model's post-edge view is queued for the monitor.
    task automatic cyc(input bit r, input bit s, input bit p, input logic [31:0] ja);
        exp_t e;
        @(negedge clk);
        reset   = r;
        Stall   = s;
        PCSrc   = p;
        JmpAddr = ja;
        if (r) begin
            m_pc = RST_PC; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            m_jc = 0; m_sc = 0; m_boot = 1'b1;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (s) begin
            m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
        end else if (p && m_valid) begin
            m_pc    = ja & 32'hFFFF_FFFC;
            m_inst  = 32'h0;
            m_pc4   = 32'h0;
            m_valid = 1'b0;
            m_jc    = (m_jc < CMAX) ? m_jc + 1 : CMAX;
        end else begin
            m_inst  = mem_word(m_pc);
            m_pc    = m_pc + 32'd4;
            m_pc4   = m_pc;
            m_valid = 1'b1;
        end
        e.pc = m_pc; e.inst = m_inst; e.pc4 = m_pc4; e.valid = m_valid;
        e.jc = m_jc; e.sc = m_sc;
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Monitor: after every active edge compare the DUT against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                chk("InstAddr",      InstAddr,                 e.pc);
                chk("IF_ID_Inst",    IF_ID_Inst,               e.inst);
                chk("IF_ID_PCPlus4", IF_ID_PCPlus4,            e.pc4);
                chk("IF_ID_Valid",   32'(IF_ID_Valid),         32'(e.valid));
                chk("JmpCount",      32'(JmpCount),            32'(e.jc));
                chk("StallCount",    32'(StallCount),          32'(e.sc));
            end
        end
    end

    initial begin
        bit r, s, p;
        logic [31:0] ja;

        // Reset, boot, free run to PC=0x20, 3-cycle stall, resume.
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        cyc(0, 1, 1, 32'h80);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);

        // Single-cycle jump to 0x100.
        cyc(0, 0, 1, 32'h0000_0100);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);

        // Stall and PCSrc together for 2 cycles, then redirect on first free cycle.
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        cyc(0, 1, 1, 32'h40); cyc(0, 1, 1, 32'h40);
        cyc(0, 0, 1, 32'h40);
        for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0);

        // Misaligned jump near the top of memory, then wrap to zero.
        cyc(0, 0, 1, 32'hFFFF_FFFE);
        cyc(0, 0, 1, 32'h0000_0200);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);

        // Reset during SQUASH, then reset during a stall.
        cyc(0, 0, 1, 32'h300);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);

        // Counter saturation.
        for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 1, 32'h1000 + 32'(i) * 32'h10);
            cyc(0, 0, 0, 0);
        end

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 99) < 2);
            s  = ($urandom_range(0, 99) < 30);
            p  = ($urandom_range(0, 99) < 30);
            ja = $urandom;
            if ($urandom_range(0, 9) == 0) ja = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            cyc(r, s, p, ja);
        end

        cyc(0, 0, 0, 0);
        @(posedge clk); #2;
        @(posedge clk); #2;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
